modport_counter: RTL and testbench

Loadable 4-bit up-counter with synchronous load and count enable, built for the counter verification environment. Drivers apply `enable_i`, `load_i` and `data_i` through a clocked interface. Monitors sample `count_o`. The block is a single registered counter with no handshake and no internal state beyond the count register.

---
 rtl/counter_pkg.sv | 29 ++
 rtl/modport_counter_if.sv | 17 +
 rtl/counter_next.sv | 30 +++
 rtl/modport_counter.sv | 44 ++++
 tb/tb_modport_counter.sv | 123 ++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared width, count type and next-state decode for the counter
package counter_pkg;

    localparam int COUNT_W = 4;

    typedef logic [COUNT_W-1:0] count_t;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_INC   = 2'd1,
        OP_LOAD  = 2'd2,
        OP_RESET = 2'd3
    } op_e;

    // Single source of the reset > load > enable > hold priority
    function automatic op_e decode_op(input logic rst, input logic load, input logic enable);
        if (rst) begin
            return OP_RESET;
        end
        if (load) begin
            return OP_LOAD;
        end
        if (enable) begin
            return OP_INC;
        end
        return OP_HOLD;
    endfunction

endpackage

// File: rtl/modport_counter_if.sv
// rtl/modport_counter_if.sv - driver/counter/monitor signal bundle for the counter
interface modport_counter_if
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNT_W
);

    logic             enable_i;
    logic             load_i;
    logic [WIDTH-1:0] data_i;
    logic [WIDTH-1:0] count_o;

    modport master  (output enable_i, load_i, data_i, input count_o);
    modport slave   (input enable_i, load_i, data_i, output count_o);
    modport monitor (input enable_i, load_i, data_i, count_o);

endinterface

// File: rtl/counter_next.sv
// rtl/counter_next.sv - combinational next-count from reset, load, enable and current count
module counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNT_W
) (
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] count_i,
    output logic [WIDTH-1:0] next_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    op_e op;

    always_comb begin
        op     = decode_op(rst_i, load_i, enable_i);
        next_o = count_i;
        case (op)
            OP_RESET: next_o = '0;
            OP_LOAD:  next_o = data_i;
            OP_INC:   next_o = count_i + ONE;
            default:  next_o = count_i;
        endcase
    end

endmodule

// File: rtl/modport_counter.sv
// rtl/modport_counter.sv - loadable up-counter with sync load and count enable
module modport_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNT_W
) (
    input logic              clk_i,
    input logic              rst_i,
    modport_counter_if.slave bus
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_nxt;

    counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .rst_i    (rst_i),
        .load_i   (bus.load_i),
        .enable_i (bus.enable_i),
        .data_i   (bus.data_i),
        .count_i  (count_q),
        .next_o   (count_nxt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_nxt;
        end
    end

    assign bus.count_o = count_q;

    a_reset_zero: assert property (@(posedge clk_i) rst_i |=> count_q == '0);

    a_load_priority: assert property (@(posedge clk_i)
        !rst_i && bus.load_i |=> count_q == $past(bus.data_i));

    a_hold: assert property (@(posedge clk_i)
        !rst_i && !bus.load_i && !bus.enable_i |=> $stable(count_q));

endmodule

// File: tb/tb_modport_counter.sv
// tb/tb_modport_counter.sv - scoreboard bench for modport_counter
module tb_modport_counter;

    logic clk_i;
    logic rst_i;

    int n_cmp;
    int n_err;

    logic [3:0] exp_q[$];
    logic [3:0] model;

    modport_counter_if #(.WIDTH(4)) bus ();

    modport_counter #(
        .WIDTH (4)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; the reference result is queued at the same time
    task automatic drive_step(input logic r, input logic l, input logic e, input logic [3:0] d);
        @(negedge clk_i);
        rst_i        = r;
        bus.load_i   = l;
        bus.enable_i = e;
        bus.data_i   = d;
        if (r) begin
            model = 4'd0;
        end else if (l) begin
            model = d;
        end else if (e) begin
            model = model + 4'd1;
        end
        exp_q.push_back(model);
    endtask

    always @(posedge clk_i) begin
        #1;
        if (exp_q.size() > 0) begin
            check_eq("count", bus.count_o, exp_q.pop_front());
        end
    end

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        model        = 4'd0;
        rst_i        = 1'b1;
        bus.load_i   = 1'b1;
        bus.enable_i = 1'b1;
        bus.data_i   = 4'h9;

        // Reset dominates load and enable
        for (int i = 0; i < 2; i++) begin
            drive_step(1'b1, 1'b1, 1'b1, 4'($urandom_range(0, 15)));
        end

        // Free count through the wrap
        for (int i = 0; i < 20; i++) begin
            drive_step(1'b0, 1'b0, 1'b1, 4'($urandom_range(0, 15)));
        end

        // Load beats enable, counting resumes from the loaded value
        drive_step(1'b0, 1'b1, 1'b1, 4'hA);
        drive_step(1'b0, 1'b0, 1'b1, 4'h3);

        // Hold while data toggles
        drive_step(1'b0, 1'b1, 1'b0, 4'h5);
        for (int i = 0; i < 5; i++) begin
            drive_step(1'b0, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
        end

        // Load the top value then wrap
        drive_step(1'b0, 1'b1, 1'b0, 4'hF);
        drive_step(1'b0, 1'b0, 1'b1, 4'h0);
        drive_step(1'b0, 1'b0, 1'b1, 4'h0);

        // Mid-run reset
        drive_step(1'b1, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 7; i++) begin
            drive_step(1'b0, 1'b0, 1'b1, 4'($urandom_range(0, 15)));
        end
        drive_step(1'b1, 1'b1, 1'b1, 4'hC);
        for (int i = 0; i < 3; i++) begin
            drive_step(1'b0, 1'b0, 1'b1, 4'($urandom_range(0, 15)));
        end

        @(negedge clk_i);
        bus.enable_i = 1'b0;
        bus.load_i   = 1'b0;

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(negedge clk_i);
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
        end

        // Directed spot checks on the final state independent of the queue
        @(negedge clk_i);
        check_eq("final_count", bus.count_o, 4'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
